// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Zero divisor short-circuits straight to DONE with a flagged result.
module restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [DW-1:0] work;
    logic [VW-1:0] dvs;
    logic [VW:0]   prem;

    logic [VW:0]   shifted;
    logic [VW+1:0] trial;
    logic          qbit;
    logic [VW:0]   next_prem;
    logic [DW-1:0] next_work;
    logic          accept;
    logic          last;

    always_comb begin
        shifted   = {prem[VW-1:0], work[DW-1]};
        trial     = {1'b0, shifted} - {2'b00, dvs};
        qbit      = ~trial[VW+1];
        next_prem = qbit ? trial[VW:0] : shifted;
        next_work = {work[DW-2:0], qbit};
        accept    = start && ((state == IDLE) || (state == DONE));
        last      = (cnt == CW'(DW - 1));
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            work        <= '0;
            dvs         <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        work <= dividend;
                        dvs  <= divisor;
                        prem <= '0;
                        cnt  <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    work <= next_work;
                    prem <= next_prem;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        state       <= DONE;
                        quotient    <= next_work;
                        remainder   <= next_prem[VW-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
